// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - pipeline stall/flush controller (load-use, multi-cycle multiply, taken branch); optional perf counters via HAZARD_PERF_CNT_EN
module hazard_stall_unit #(
    parameter int MULT_LAT = 4,
    parameter int REG_W    = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_uses_rt,
    input  logic             IE_memread,
    input  logic [REG_W-1:0] IE_rt,
    input  logic             IE_mult_start,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_write,
    output logic             IDEX_flush,
    output logic             EXMEM_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]      perf_lu_cnt,
    output logic [31:0]      perf_mult_cnt,
    output logic [31:0]      perf_flush_cnt,
`endif
    output logic             busy
);

    // Counter is loaded at the start cycle, so the start cycle itself is the first stall
    localparam logic [3:0] LP_CNT_INIT = 4'(MULT_LAT - 2);

    typedef enum logic {
        RUN  = 1'b0,
        MULT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    logic       w_load_use;
    logic       w_lu_bubble;
    logic       w_mult_stall;
    logic       w_br_flush;

    // Load-use detection; a load into $0 never creates a dependency
    always_comb begin
        w_load_use = IE_memread && (IE_rt != '0) &&
                     ((IE_rt == ID_rs) || (ID_uses_rt && (IE_rt == ID_rt)));
    end

    // State and countdown register, reset aborts any multiply sequence
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and outputs; priority is reset > branch > multiply > load-use
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        pc_write     = 1'b1;
        IFID_write   = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_write   = 1'b1;
        IDEX_flush   = 1'b0;
        EXMEM_flush  = 1'b0;
        busy         = 1'b0;
        w_lu_bubble  = 1'b0;
        w_mult_stall = 1'b0;
        w_br_flush   = 1'b0;

        if (rst_i) begin
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
        end else if (branch_taken) begin
            // The branch is older than anything in EX, so it also kills a multiply
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
            w_br_flush  = 1'b1;
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (IE_mult_start) begin
                        pc_write     = 1'b0;
                        IFID_write   = 1'b0;
                        IDEX_write   = 1'b0;
                        EXMEM_flush  = 1'b1;
                        busy         = 1'b1;
                        w_mult_stall = 1'b1;
                        w_state_nxt  = MULT;
                        w_cnt_nxt    = LP_CNT_INIT;
                    end else if (w_load_use) begin
                        // One bubble; next cycle the load is in EX/MEM and the hazard clears
                        pc_write    = 1'b0;
                        IFID_write  = 1'b0;
                        IDEX_flush  = 1'b1;
                        w_lu_bubble = 1'b1;
                    end
                end
                MULT: begin
                    busy = 1'b1;
                    if (r_cnt != '0) begin
                        pc_write     = 1'b0;
                        IFID_write   = 1'b0;
                        IDEX_write   = 1'b0;
                        EXMEM_flush  = 1'b1;
                        w_mult_stall = 1'b1;
                        w_cnt_nxt    = r_cnt - 4'd1;
                    end else begin
                        // Release: product latches into EX/MEM with normal advance
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_mult;
    logic [31:0] r_perf_flush;

    // Event counters, free-running with natural 32-bit wrap
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_lu    <= '0;
            r_perf_mult  <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_lu_bubble)  r_perf_lu    <= r_perf_lu + 32'd1;
            if (w_mult_stall) r_perf_mult  <= r_perf_mult + 32'd1;
            if (w_br_flush)   r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_lu_cnt    = r_perf_lu;
    assign perf_mult_cnt  = r_perf_mult;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_uses_rt;
    logic       IE_memread;
    logic [4:0] IE_rt;
    logic       IE_mult_start;
    logic       branch_taken;
    logic       pc_write;
    logic       IFID_write;
    logic       IFID_flush;
    logic       IDEX_write;
    logic       IDEX_flush;
    logic       EXMEM_flush;
    logic       busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_cnt;
    logic [31:0] perf_mult_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // {pc_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_flush, busy}
    localparam logic [6:0] E_RST = 7'b0010110;
    localparam logic [6:0] E_DEF = 7'b1101000;
    localparam logic [6:0] E_LU  = 7'b0001100;
    localparam logic [6:0] E_MST = 7'b0000011;
    localparam logic [6:0] E_REL = 7'b1101001;
    localparam logic [6:0] E_BR  = 7'b1111110;

    hazard_stall_unit #(.MULT_LAT(4), .REG_W(5)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ID_rs         (ID_rs),
        .ID_rt         (ID_rt),
        .ID_uses_rt    (ID_uses_rt),
        .IE_memread    (IE_memread),
        .IE_rt         (IE_rt),
        .IE_mult_start (IE_mult_start),
        .branch_taken  (branch_taken),
        .pc_write      (pc_write),
        .IFID_write    (IFID_write),
        .IFID_flush    (IFID_flush),
        .IDEX_write    (IDEX_write),
        .IDEX_flush    (IDEX_flush),
        .EXMEM_flush   (EXMEM_flush),
`ifdef HAZARD_PERF_CNT_EN
        .perf_lu_cnt   (perf_lu_cnt),
        .perf_mult_cnt (perf_mult_cnt),
        .perf_flush_cnt(perf_flush_cnt),
`endif
        .busy          (busy)
    );

    always #5 clk_i = ~clk_i;

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        @(negedge clk_i);
        obs = {pc_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_flush, busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0;
        IE_memread = 1'b0; IE_rt = 5'd0; IE_mult_start = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        #1;
        check_out("reset_c1", E_RST);
        next_cycle();
        check_out("reset_c2", E_RST);
        next_cycle();
        rst_i = 1'b0;
        check_out("after_reset", E_DEF);

        // load-use on rs
        next_cycle();
        IE_memread = 1'b1; IE_rt = 5'd8; ID_rs = 5'd8;
        check_out("lu_rs", E_LU);
        next_cycle();
        idle();
        check_out("lu_rs_clear", E_DEF);

        // load into $0 never stalls
        next_cycle();
        IE_memread = 1'b1; IE_rt = 5'd0; ID_rs = 5'd0;
        check_out("lu_zero", E_DEF);

        // rt match without rt use does not stall, with rt use does
        next_cycle();
        IE_memread = 1'b1; IE_rt = 5'd8; ID_rs = 5'd3; ID_rt = 5'd8; ID_uses_rt = 1'b0;
        check_out("lu_rt_unused", E_DEF);
        next_cycle();
        ID_uses_rt = 1'b1;
        check_out("lu_rt_used", E_LU);

        // multiply: start cycle also carries a load-use match (illegal decode, mult wins)
        next_cycle();
        idle();
        IE_mult_start = 1'b1; IE_memread = 1'b1; IE_rt = 5'd9; ID_rs = 5'd9;
        check_out("mult_start", E_MST);
        next_cycle();
        check_out("mult_stall2", E_MST);
        next_cycle();
        check_out("mult_stall3", E_MST);
        next_cycle();
        check_out("mult_release", E_REL);
        next_cycle();
        idle();
        check_out("mult_after", E_DEF);

        // branch on stall cycle 2 kills the multiply
        next_cycle();
        IE_mult_start = 1'b1;
        check_out("br_mult_start", E_MST);
        next_cycle();
        branch_taken = 1'b1;
        check_out("br_flush", E_BR);
        next_cycle();
        idle();
        check_out("br_after", E_DEF);

        // reset on stall cycle 2 aborts the multiply
        next_cycle();
        IE_mult_start = 1'b1;
        check_out("rst_mult_start", E_MST);
        next_cycle();
        rst_i = 1'b1;
        check_out("rst_mid_mult", E_RST);
        next_cycle();
        rst_i = 1'b0;
        idle();
        check_out("rst_after", E_DEF);

`ifdef HAZARD_PERF_CNT_EN
        // since the mid-multiply reset: one load-use, one full multiply, one branch
        next_cycle();
        IE_memread = 1'b1; IE_rt = 5'd8; ID_rs = 5'd8;
        check_out("perf_lu", E_LU);
        next_cycle();
        idle();
        IE_mult_start = 1'b1;
        check_out("perf_m1", E_MST);
        next_cycle();
        check_out("perf_m2", E_MST);
        next_cycle();
        check_out("perf_m3", E_MST);
        next_cycle();
        check_out("perf_rel", E_REL);
        next_cycle();
        idle();
        branch_taken = 1'b1;
        check_out("perf_br", E_BR);
        next_cycle();
        idle();
        check_val("perf_lu_cnt", perf_lu_cnt, 32'd1);
        check_val("perf_mult_cnt", perf_mult_cnt, 32'd3);
        check_val("perf_flush_cnt", perf_flush_cnt, 32'd1);
`endif

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall and flush controller for the 5-stage pipeline; the counterpart of the forwarding unit.
- Covers the hazards forwarding cannot resolve:
  - load-use (one-bubble stall),
  - multi-cycle multiply occupying EX (counted stall),
  - taken branch resolved at EX/MEM (flush).
- Sits beside the forwarding unit and drives write-enables/flushes of PC, IF/ID, ID/EX, EX/MEM.

Parameters:
- MULT_LAT, 4, cycles a multiply occupies EX including its start cycle; legal range 2..16.
- REG_W, 5, register-specifier width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ID_rs  in  REG_W  rs of instruction in IF/ID
- ID_rt  in  REG_W  rt of instruction in IF/ID
- ID_uses_rt  in  1  instruction in IF/ID reads rt as a source
- IE_memread  in  1  ID/EX instruction is a load
- IE_rt  in  REG_W  load destination in ID/EX
- IE_mult_start  in  1  ID/EX instruction is a multiply (held high while it sits in EX)
- branch_taken  in  1  taken branch in EX/MEM, one-cycle pulse
- pc_write  out  1  PC load enable
- IFID_write  out  1  IF/ID load enable
- IFID_flush  out  1  clear IF/ID to nop
- IDEX_write  out  1  ID/EX load enable
- IDEX_flush  out  1  load nop into ID/EX
- EXMEM_flush  out  1  load nop into EX/MEM
- busy  out  1  multiply stall sequence active

Behaviour:
- Default outputs (normal advance): pc_write=1, IFID_write=1, IDEX_write=1, all flushes=0.
- State machine: RUN, MULT. 4-bit down-counter cnt. Outputs are combinational from state, cnt and inputs.
- Reset: while rst_i=1, outputs are forced to pc_write=0, IFID_write=0, IDEX_write=0, IFID_flush=1, IDEX_flush=1, EXMEM_flush=1, busy=0.
  - Next state is RUN with cnt=0.
  - Reset mid-MULT aborts the sequence immediately.
- Load-use hazard: load_use = IE_memread & (IE_rt!=0) & ((IE_rt==ID_rs) | (ID_uses_rt & IE_rt==ID_rt)).
- Priority per cycle: branch_taken > MULT-state/mult-start > load_use.
- branch_taken=1, any state:
  - IFID_flush=1, IDEX_flush=1, EXMEM_flush=1; pc_write=1, IFID_write=1, IDEX_write=1.
  - Next state RUN, cnt=0. The branch is older, so it kills any multiply in EX.
- RUN, IE_mult_start=1 (start cycle):
  - pc_write=0, IFID_write=0, IDEX_write=0, EXMEM_flush=1, busy=1.
  - Next state MULT, cnt=MULT_LAT-2.
- MULT, cnt!=0:
  - Same stall outputs as the start cycle; cnt decrements.
  - IE_mult_start and load_use are ignored.
- MULT, cnt==0 (release cycle):
  - Default outputs; the product latches into EX/MEM.
  - busy=1 this cycle; next state RUN.
- Stall length: exactly MULT_LAT-1 stalled cycles; release on cycle MULT_LAT. MULT_LAT=2 gives one stall cycle.
- RUN, load_use=1, no mult start:
  - pc_write=0, IFID_write=0, IDEX_write=1, IDEX_flush=1 (one bubble).
  - Stays in RUN. The next cycle sees the load in EX/MEM, so load_use clears without extra state.
- $0 never causes a load-use stall.
- IE_memread and IE_mult_start both high is illegal decode; mult handling wins.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_lu_cnt[31:0], perf_mult_cnt[31:0], perf_flush_cnt[31:0].
  - Each increments by 1 per cycle in which a load-use bubble / multiply stall cycle / branch flush is issued.
  - Counters wrap at 2^32, clear on rst_i, and are not incremented during reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: rst_i=1 for 2 cycles -> pc_write=0, IDEX_write=0, all flushes=1, busy=0; first cycle after release with idle inputs -> default outputs.
- Load-use: IE_memread=1, IE_rt=8, ID_rs=8 -> exactly 1 cycle of pc_write=0, IFID_write=0, IDEX_flush=1. Same with IE_rt=0 -> no stall. ID_rt=8 with ID_uses_rt=0 -> no stall.
- Multiply, MULT_LAT=4: IE_mult_start held high 4 cycles -> 3 cycles of pc_write=0, IDEX_write=0, EXMEM_flush=1, busy=1; 4th cycle default outputs; then RUN.
- Branch mid-multiply: branch_taken pulse on stall cycle 2 -> that cycle all three flushes=1, pc_write=1; next cycle RUN, busy=0.
- Reset mid-multiply: rst_i pulsed on stall cycle 2 -> following cycle RUN, busy=0, no residual stall.
- With HAZARD_PERF_CNT_EN: one load-use, one MULT_LAT=4 multiply, one branch -> perf_lu_cnt=1, perf_mult_cnt=3, perf_flush_cnt=1.
